// File: rtl/trafficlight_controller_if.sv
// Lamp bundle for the traffic light controller: the four 3-bit {R,Y,G}
// lamp groups, with a driving view and an observing view.
interface trafficlight_controller_if;
    logic [2:0] m1;
    logic [2:0] m2;
    logic [2:0] mt;
    logic [2:0] s;

    modport master (output m1, output m2, output mt, output s);
    modport slave  (input  m1, input  m2, input  mt, input  s);
endinterface

// File: rtl/trafficlight_controller.sv
// Six-state fixed-cycle traffic light controller.
// Each state dwells for its own T_x cycles, tracked by an 8-bit counter that
// restarts on every state entry. Lamps are one-hot {R,Y,G}. They are held in
// flops loaded from the decode of the next state, so they change on the same
// edge as the state itself.
module trafficlight_controller #(
    parameter int unsigned T_MAIN = 7,
    parameter int unsigned T_M2Y  = 2,
    parameter int unsigned T_TURN = 5,
    parameter int unsigned T_MY   = 2,
    parameter int unsigned T_SIDE = 3,
    parameter int unsigned T_SY   = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic [2:0] M1,
    output logic [2:0] M2,
    output logic [2:0] MT,
    output logic [2:0] S
);

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    // Counter values on which each state hands over (T_x - 1).
    localparam logic [7:0] LIM_S1 = 8'(T_MAIN - 1);
    localparam logic [7:0] LIM_S2 = 8'(T_M2Y  - 1);
    localparam logic [7:0] LIM_S3 = 8'(T_TURN - 1);
    localparam logic [7:0] LIM_S4 = 8'(T_MY   - 1);
    localparam logic [7:0] LIM_S5 = 8'(T_SIDE - 1);
    localparam logic [7:0] LIM_S6 = 8'(T_SY   - 1);

    typedef enum logic [2:0] {
        ST_S1 = 3'd0,
        ST_S2 = 3'd1,
        ST_S3 = 3'd2,
        ST_S4 = 3'd3,
        ST_S5 = 3'd4,
        ST_S6 = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] m1_q, m1_d;
    logic [2:0] m2_q, m2_d;
    logic [2:0] mt_q, mt_d;
    logic [2:0] s_q,  s_d;

    state_t     nxt_s;
    logic [7:0] lim_s;
    logic       illegal_s;

    // State, dwell counter and lamp registers; reset parks everything in S1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_S1;
            cnt_q   <= 8'd0;
            m1_q    <= LAMP_G;
            m2_q    <= LAMP_G;
            mt_q    <= LAMP_R;
            s_q     <= LAMP_R;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m1_q    <= m1_d;
            m2_q    <= m2_d;
            mt_q    <= mt_d;
            s_q     <= s_d;
        end
    end

    // Next state and dwell counter: advance when the counter reaches T_x-1,
    // and pull any unused encoding straight back to S1.
    always_comb begin
        nxt_s     = ST_S1;
        lim_s     = 8'd0;
        illegal_s = 1'b0;
        state_d   = ST_S1;
        cnt_d     = 8'd0;
        case (state_q)
            ST_S1:   begin nxt_s = ST_S2; lim_s = LIM_S1; end
            ST_S2:   begin nxt_s = ST_S3; lim_s = LIM_S2; end
            ST_S3:   begin nxt_s = ST_S4; lim_s = LIM_S3; end
            ST_S4:   begin nxt_s = ST_S5; lim_s = LIM_S4; end
            ST_S5:   begin nxt_s = ST_S6; lim_s = LIM_S5; end
            ST_S6:   begin nxt_s = ST_S1; lim_s = LIM_S6; end
            default: begin nxt_s = ST_S1; lim_s = 8'd0; illegal_s = 1'b1; end
        endcase
        if (illegal_s) begin
            state_d = ST_S1;
            cnt_d   = 8'd0;
        end else if (cnt_q == lim_s) begin
            state_d = nxt_s;
            cnt_d   = 8'd0;
        end else begin
            state_d = state_q;
            cnt_d   = cnt_q + 8'd1;
        end
    end

    // Lamp decode of the state being entered; anything unexpected shows all red.
    always_comb begin
        m1_d = LAMP_R;
        m2_d = LAMP_R;
        mt_d = LAMP_R;
        s_d  = LAMP_R;
        case (state_d)
            ST_S1:   begin m1_d = LAMP_G; m2_d = LAMP_G; mt_d = LAMP_R; s_d = LAMP_R; end
            ST_S2:   begin m1_d = LAMP_G; m2_d = LAMP_Y; mt_d = LAMP_R; s_d = LAMP_R; end
            ST_S3:   begin m1_d = LAMP_G; m2_d = LAMP_R; mt_d = LAMP_G; s_d = LAMP_R; end
            ST_S4:   begin m1_d = LAMP_Y; m2_d = LAMP_R; mt_d = LAMP_Y; s_d = LAMP_R; end
            ST_S5:   begin m1_d = LAMP_R; m2_d = LAMP_R; mt_d = LAMP_R; s_d = LAMP_G; end
            ST_S6:   begin m1_d = LAMP_R; m2_d = LAMP_R; mt_d = LAMP_R; s_d = LAMP_Y; end
            default: begin m1_d = LAMP_R; m2_d = LAMP_R; mt_d = LAMP_R; s_d = LAMP_R; end
        endcase
    end

    assign M1 = m1_q;
    assign M2 = m2_q;
    assign MT = mt_q;
    assign S  = s_q;

endmodule

// File: tb/tb_trafficlight_controller.sv
// Scoreboard bench for trafficlight_controller: one instance with default
// timing and one with every dwell set to 1. Stimulus pushes the expected lamp
// vector {M1,M2,MT,S} for each upcoming cycle; a monitor pops and compares on
// every falling edge, and also checks one-hot / no-conflict / no-X.
module tb_trafficlight_controller;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic mon_on = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [11:0] q0[$];
    logic [11:0] q1[$];

    trafficlight_controller_if lamps0 ();
    trafficlight_controller_if lamps1 ();

    trafficlight_controller dut0 (
        .clk   (clk),
        .reset (reset),
        .M1    (lamps0.m1),
        .M2    (lamps0.m2),
        .MT    (lamps0.mt),
        .S     (lamps0.s)
    );

    trafficlight_controller #(
        .T_MAIN (1), .T_M2Y (1), .T_TURN (1),
        .T_MY   (1), .T_SIDE (1), .T_SY  (1)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .M1    (lamps1.m1),
        .M2    (lamps1.m2),
        .MT    (lamps1.mt),
        .S     (lamps1.s)
    );

    always #5 clk = ~clk;

    // Hand-written lamp vectors {M1,M2,MT,S} for S1..S6.
    function automatic logic [11:0] state_vec(input int idx);
        case (idx)
            0: return 12'b001_001_100_100;
            1: return 12'b001_010_100_100;
            2: return 12'b001_100_001_100;
            3: return 12'b010_100_010_100;
            4: return 12'b100_100_100_001;
            5: return 12'b100_100_100_010;
            default: return 12'b000_000_000_000;
        endcase
    endfunction

    // Default timing: cycle n (1-based after release) inside a 21-cycle frame
    // of 7xS1, 2xS2, 5xS3, 2xS4, 3xS5, 2xS6.
    function automatic logic [11:0] main_seq(input int n);
        int r;
        r = (n - 1) % 21;
        if (r < 7)       return state_vec(0);
        else if (r < 9)  return state_vec(1);
        else if (r < 14) return state_vec(2);
        else if (r < 16) return state_vec(3);
        else if (r < 19) return state_vec(4);
        else             return state_vec(5);
    endfunction

    // All dwells 1: one state per cycle, period 6.
    function automatic logic [11:0] fast_seq(input int n);
        return state_vec((n - 1) % 6);
    endfunction

    function automatic logic is_lamp(input logic [2:0] v);
        return (v === 3'b100) || (v === 3'b010) || (v === 3'b001);
    endfunction

    // One-hot everywhere and side road lit only with all main lamps red.
    function automatic logic lamps_safe(input logic [11:0] v);
        logic [2:0] m1, m2, mt, s;
        m1 = v[11:9]; m2 = v[8:6]; mt = v[5:3]; s = v[2:0];
        if (!(is_lamp(m1) && is_lamp(m2) && is_lamp(mt) && is_lamp(s))) return 1'b0;
        if (s !== 3'b100 && !(m1 === 3'b100 && m2 === 3'b100 && mt === 3'b100)) return 1'b0;
        return 1'b1;
    endfunction

    // Falling-edge monitor: invariants every cycle, scoreboard pop when queued.
    always @(negedge clk) begin
        logic [11:0] a0, a1, e;
        if (mon_on) begin
            a0 = {lamps0.m1, lamps0.m2, lamps0.mt, lamps0.s};
            a1 = {lamps1.m1, lamps1.m2, lamps1.mt, lamps1.s};
            total += 2;
            if ($isunknown(a0) || !lamps_safe(a0)) begin
                bad++;
                $display("FAIL safe0 t=%0t got=%b need one-hot, no conflict, no X", $time, a0);
            end
            if ($isunknown(a1) || !lamps_safe(a1)) begin
                bad++;
                $display("FAIL safe1 t=%0t got=%b need one-hot, no conflict, no X", $time, a1);
            end
            if (q0.size() > 0) begin
                e = q0.pop_front();
                total++;
                if (a0 !== e) begin
                    bad++;
                    $display("FAIL seq0 t=%0t got=%b exp=%b", $time, a0, e);
                end
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                total++;
                if (a1 !== e) begin
                    bad++;
                    $display("FAIL seq1 t=%0t got=%b exp=%b", $time, a1, e);
                end
            end
        end
    end

    // Release reset just after a rising edge and queue the expected cycles.
    task automatic release_and_push(input int n0, input int n1);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 1; i <= n0; i++) q0.push_back(main_seq(i));
        for (int i = 1; i <= n1; i++) q1.push_back(fast_seq(i));
    endtask

    // Wait for the monitor to consume both queues, bounded.
    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((q0.size() > 0 || q1.size() > 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        #1;
        total++;
        if (q0.size() > 0 || q1.size() > 0) begin
            bad++;
            $display("FAIL drain left=%0d/%0d need 0/0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic check_now(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, act, exp);
        end
    endtask

    task automatic assert_reset();
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        mon_on = 1'b1;
        check_now("reset0", {lamps0.m1, lamps0.m2, lamps0.mt, lamps0.s}, 12'b001_001_100_100);
        check_now("reset1", {lamps1.m1, lamps1.m2, lamps1.mt, lamps1.s}, 12'b001_001_100_100);

        // One full frame plus the return to S1.
        release_and_push(22, 22);
        drain(40);

        // Async reset between edges during S3, then a full S1 dwell.
        assert_reset();
        release_and_push(11, 11);
        repeat (11) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check_now("async0", {lamps0.m1, lamps0.m2, lamps0.mt, lamps0.s}, 12'b001_001_100_100);
        check_now("async1", {lamps1.m1, lamps1.m2, lamps1.mt, lamps1.s}, 12'b001_001_100_100);
        total++;
        if (q0.size() != 0) begin
            bad++;
            $display("FAIL async_q left=%0d need 0", q0.size());
            q0.delete();
            q1.delete();
        end
        release_and_push(8, 8);
        drain(20);

        // 100-clock free run: period 21 (default) and 6 (unit dwells).
        assert_reset();
        release_and_push(100, 100);
        drain(120);

        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog t=%0t need finish before timeout", $time);
        $fatal(1);
    end

endmodule

// File: doc/trafficlight_controller.md
TRAFFICLIGHT_CONTROLLER -- requirements
Module: trafficlight_controller

Interface
REQ-001 The block SHALL have one clock, `clk`; reset, `reset`, SHALL be asynchronous and active-high.
REQ-002 Parameter T_MAIN SHALL have default 7 and set the cycles in S1 (M1+M2 green).
REQ-003 Parameter T_M2Y SHALL have default 2 and set the cycles in S2 (M2 yellow).
REQ-004 Parameter T_TURN SHALL have default 5 and set the cycles in S3 (M1+MT green).
REQ-005 Parameter T_MY SHALL have default 2 and set the cycles in S4 (M1+MT yellow).
REQ-006 Parameter T_SIDE SHALL have default 3 and set the cycles in S5 (S green).
REQ-007 Parameter T_SY SHALL have default 2 and set the cycles in S6 (S yellow).
REQ-008 Port `clk` SHALL be an input, 1 bit wide, rising-edge clock.
REQ-009 Port `reset` SHALL be an input, 1 bit wide, asynchronous active-high reset.
REQ-010 Port M1 SHALL be an output, 3 bits wide, main road direction 1 lamp.
REQ-011 Port M2 SHALL be an output, 3 bits wide, main road direction 2 lamp.
REQ-012 Port MT SHALL be an output, 3 bits wide, main road turn lamp.
REQ-013 Port S SHALL be an output, 3 bits wide, side road lamp.
REQ-014 Port order SHALL be clk, reset, M1, M2, MT, S, so positional instantiation works.

Function
REQ-015 Lamp encoding SHALL be one-hot {R,Y,G}: 3'b100 red, 3'b010 yellow, 3'b001 green; no other value SHALL ever be driven.
REQ-016 The FSM SHALL have six states S1..S6 in a fixed cycle S1->S2->S3->S4->S5->S6->S1; the block has no other inputs.
REQ-017 In S1, lamps SHALL be M1=G, M2=G, MT=R, S=R.
REQ-018 In S2, lamps SHALL be M1=G, M2=Y, MT=R, S=R.
REQ-019 In S3, lamps SHALL be M1=G, M2=R, MT=G, S=R.
REQ-020 In S4, lamps SHALL be M1=Y, M2=R, MT=Y, S=R.
REQ-021 In S5, lamps SHALL be M1=R, M2=R, MT=R, S=G.
REQ-022 In S6, lamps SHALL be M1=R, M2=R, MT=R, S=Y.
REQ-023 Outputs SHALL be a pure Moore decode of the registered state, with no extra pipeline cycle: they change in the same clock edge as the state.
REQ-024 An 8-bit dwell counter SHALL clear to 0 on every state entry and increment each clock; the state SHALL advance on the rising edge where counter == T_x-1, so each state lasts exactly T_x cycles.
REQ-025 All T_x parameters SHALL be in the range 1..255; T_x=1 SHALL give a one-cycle state.
REQ-026 One full cycle with default parameters SHALL take 21 clocks.
REQ-027 An illegal or unused state encoding SHALL recover to S1 with counter 0 on the next clock.
REQ-028 No conflicting greens SHALL occur: S is green or yellow only when M1, M2 and MT are all red.

Reset
REQ-029 While reset=1, the block SHALL immediately (asynchronously) force state S1 and counter 0, so outputs read M1=001, M2=001, MT=100, S=100.
REQ-030 Reset asserted mid-state SHALL abort the current dwell; after release the block SHALL spend a full T_MAIN cycles in S1.
REQ-031 After reset deassertion, the first rising edge SHALL count as cycle 1 of S1.

Verification
REQ-032 Bench SHALL check: reset pulse, then 7 clocks -> S1 outputs for 7 clocks, then M2=010 with M1=001.
REQ-033 Bench SHALL check: run from reset through 21 clocks -> output sequence 7xS1, 2xS2, 5xS3, 2xS4, 3xS5, 2xS6, then S1 again.
REQ-034 Bench SHALL check: at every clock each output is one-hot, and S!=100 implies M1=M2=MT=100.
REQ-035 Bench SHALL check: reset asserted asynchronously, between clock edges, during S3 -> outputs immediately become 001/001/100/100, and after release S1 lasts 7 clocks.
REQ-036 Bench SHALL check: with all T_x=1 -> the state changes on every clock and the period is 6 clocks.
REQ-037 Bench SHALL check: 100-clock free run -> the pattern repeats with period 21 and no X on any output after reset.
